// File: rtl/ram2149_arbiter.sv
// Front end for a single 1Kx4 2149-style SRAM. It fills the array after reset,
// then arbitrates between a CPU read/write port and a read-only video port.
//
// state  | meaning
// CLEAR  | post-reset fill, one word written per cycle
// IDLE   | pick one eligible requester and drive the RAM strobes
// ACCESS | RAM cycle in flight; capture read data and pulse the completion strobe
module ram2149_arbiter #(
  parameter int                ADDR_W         = 10,
  parameter int                DATA_W         = 4,
  parameter bit                CLEAR_ON_RESET = 1'b1,
  parameter logic [DATA_W-1:0] CLEAR_VAL      = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic              vid_valid,
  output logic [DATA_W-1:0] vid_rdata,
  output logic              busy,
  output logic [ADDR_W-1:0] ram_A,
  output logic [DATA_W-1:0] ram_Din,
  input  logic [DATA_W-1:0] ram_Dout,
  output logic              ram_CS_b,
  output logic              ram_WE_b
);

  typedef enum logic [1:0] {
    ST_CLEAR  = 2'd0,
    ST_IDLE   = 2'd1,
    ST_ACCESS = 2'd2
  } state_t;

  localparam state_t RESET_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   ram_a_q, ram_a_d;
  logic [DATA_W-1:0]   ram_din_q, ram_din_d;
  logic                ram_cs_b_q, ram_cs_b_d;
  logic                ram_we_b_q, ram_we_b_d;
  logic                cpu_ack_q, cpu_ack_d;
  logic                vid_valid_q, vid_valid_d;
  logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0]   vid_rdata_q, vid_rdata_d;
  logic                busy_q, busy_d;
  logic                grant_vid_q, grant_vid_d;
  logic                last_vid_q, last_vid_d;

  logic cpu_elig;
  logic vid_elig;
  logic pick_cpu;
  logic pick_vid;
  logic fill_started;
  logic fill_last;

  // A port whose completion strobe is high this cycle is still releasing its
  // request, so it must not be granted again on the closing edge.
  assign cpu_elig = cpu_req & ~cpu_ack_q;
  assign vid_elig = vid_req & ~vid_valid_q;
  // Video normally wins; CPU wins right after a video grant so it cannot starve.
  assign pick_cpu = cpu_elig & (~vid_elig | last_vid_q);
  assign pick_vid = vid_elig & ~pick_cpu;

  // The fill drives its strobes low on the first cycle, so a deasserted chip
  // select inside CLEAR means the first word has not been set up yet.
  assign fill_started = ~ram_cs_b_q;
  assign fill_last    = fill_started & (ram_a_q == {ADDR_W{1'b1}});

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= RESET_STATE;
      ram_a_q     <= '0;
      ram_din_q   <= '0;
      ram_cs_b_q  <= 1'b1;
      ram_we_b_q  <= 1'b1;
      cpu_ack_q   <= 1'b0;
      vid_valid_q <= 1'b0;
      cpu_rdata_q <= '0;
      vid_rdata_q <= '0;
      busy_q      <= CLEAR_ON_RESET;
      grant_vid_q <= 1'b0;
      last_vid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      ram_a_q     <= ram_a_d;
      ram_din_q   <= ram_din_d;
      ram_cs_b_q  <= ram_cs_b_d;
      ram_we_b_q  <= ram_we_b_d;
      cpu_ack_q   <= cpu_ack_d;
      vid_valid_q <= vid_valid_d;
      cpu_rdata_q <= cpu_rdata_d;
      vid_rdata_q <= vid_rdata_d;
      busy_q      <= busy_d;
      grant_vid_q <= grant_vid_d;
      last_vid_q  <= last_vid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_CLEAR: begin
        if (fill_last) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (pick_cpu | pick_vid) state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    ram_a_d     = ram_a_q;
    ram_din_d   = ram_din_q;
    ram_cs_b_d  = 1'b1;
    ram_we_b_d  = 1'b1;
    cpu_ack_d   = 1'b0;
    vid_valid_d = 1'b0;
    cpu_rdata_d = cpu_rdata_q;
    vid_rdata_d = vid_rdata_q;
    busy_d      = busy_q;
    grant_vid_d = grant_vid_q;
    last_vid_d  = last_vid_q;

    case (state_q)
      ST_CLEAR: begin
        if (!fill_started) begin
          ram_a_d    = '0;
          ram_din_d  = CLEAR_VAL;
          ram_cs_b_d = 1'b0;
          ram_we_b_d = 1'b0;
        end else if (fill_last) begin
          busy_d = 1'b0;
        end else begin
          ram_a_d    = ram_a_q + 1'b1;
          ram_din_d  = CLEAR_VAL;
          ram_cs_b_d = 1'b0;
          ram_we_b_d = 1'b0;
        end
      end
      ST_IDLE: begin
        if (pick_cpu) begin
          ram_a_d     = cpu_addr;
          ram_din_d   = cpu_wdata;
          ram_cs_b_d  = 1'b0;
          ram_we_b_d  = ~cpu_we;
          grant_vid_d = 1'b0;
          last_vid_d  = 1'b0;
        end else if (pick_vid) begin
          ram_a_d     = vid_addr;
          ram_din_d   = cpu_wdata;
          ram_cs_b_d  = 1'b0;
          ram_we_b_d  = 1'b1;
          grant_vid_d = 1'b1;
          last_vid_d  = 1'b1;
        end
      end
      ST_ACCESS: begin
        // For a CPU write this captures the pre-write contents; users ignore it.
        if (grant_vid_q) begin
          vid_rdata_d = ram_Dout;
          vid_valid_d = 1'b1;
        end else begin
          cpu_rdata_d = ram_Dout;
          cpu_ack_d   = 1'b1;
        end
      end
      default: begin
        busy_d = 1'b0;
      end
    endcase
  end

  assign cpu_ack   = cpu_ack_q;
  assign cpu_rdata = cpu_rdata_q;
  assign vid_valid = vid_valid_q;
  assign vid_rdata = vid_rdata_q;
  assign busy      = busy_q;
  assign ram_A     = ram_a_q;
  assign ram_Din   = ram_din_q;
  assign ram_CS_b  = ram_cs_b_q;
  assign ram_WE_b  = ram_we_b_q;

endmodule

// File: tb/tb_ram2149_arbiter.sv
// Bench for ram2149_arbiter: behavioural 2149 model, directed stimulus, and a
// per-port scoreboard whose monitor checks every cpu_ack / vid_valid.
module tb_ram2149_arbiter;
  localparam int AW = 10;
  localparam int DW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          cpu_req, cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_ack;
  logic [DW-1:0] cpu_rdata;
  logic          vid_req;
  logic [AW-1:0] vid_addr;
  logic          vid_valid;
  logic [DW-1:0] vid_rdata;
  logic          busy;
  logic [AW-1:0] ram_A;
  logic [DW-1:0] ram_Din, ram_Dout;
  logic          ram_CS_b, ram_WE_b;
  logic          scrub;

  always #5 clk = ~clk;

  ram2149_arbiter #(.ADDR_W(AW), .DATA_W(DW), .CLEAR_ON_RESET(1'b1), .CLEAR_VAL(4'h0)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_valid(vid_valid), .vid_rdata(vid_rdata),
    .busy(busy), .ram_A(ram_A), .ram_Din(ram_Din), .ram_Dout(ram_Dout),
    .ram_CS_b(ram_CS_b), .ram_WE_b(ram_WE_b)
  );

  // RAM model; scrub poisons every word so only a real fill can clear it.
  logic [DW-1:0] mem [1 << AW];
  always @(posedge clk) begin
    if (scrub) begin
      for (int i = 0; i < (1 << AW); i++) mem[i] <= 4'hF;
    end else if (!ram_CS_b && !ram_WE_b) begin
      mem[ram_A] <= ram_Din;
    end
  end
  assign ram_Dout = mem[ram_A];

  typedef struct {
    bit            chk;
    logic [DW-1:0] d;
  } exp_t;
  exp_t cpu_q[$];
  exp_t vid_q[$];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_tests++;
    n_fail++;
    $display("[TB] FAIL %s: timed out at %0t", name, $time);
  endtask

  // Monitor: pops the expectation for whichever port completes.
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      if (cpu_ack === 1'b1) begin
        exp_t e;
        check("cpu ack outside busy", int'(busy), 0);
        check("cpu ack expected", int'(cpu_q.size() != 0), 1);
        if (cpu_q.size() != 0) begin
          e = cpu_q.pop_front();
          if (e.chk) check("cpu rdata", int'(cpu_rdata), int'(e.d));
        end
      end
      if (vid_valid === 1'b1) begin
        exp_t e;
        check("vid valid expected", int'(vid_q.size() != 0), 1);
        if (vid_q.size() != 0) begin
          e = vid_q.pop_front();
          if (e.chk) check("vid rdata", int'(vid_rdata), int'(e.d));
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cpu_op(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                        input logic [DW-1:0] exp_rd, output int lat);
    exp_t e;
    e.chk = !we;
    e.d   = exp_rd;
    cpu_q.push_back(e);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = wd;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (cpu_ack !== 1'b1 && lat < 100);
    if (cpu_ack !== 1'b1) timeout("cpu op wait");
    cpu_req = 1'b0;
  endtask

  task automatic vid_op(input logic [AW-1:0] a, input logic [DW-1:0] exp_rd, output int lat);
    exp_t e;
    e.chk = 1'b1;
    e.d   = exp_rd;
    vid_q.push_back(e);
    vid_req = 1'b1; vid_addr = a;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (vid_valid !== 1'b1 && lat < 100);
    if (vid_valid !== 1'b1) timeout("vid op wait");
  endtask

  // Observes a fill starting at the current negedge (first cycle after release).
  task automatic fill_watch(input bit inject, output int busy_cnt, output int we_cnt, output int seq_bad);
    busy_cnt = 0; we_cnt = 0; seq_bad = 0;
    for (int i = 0; i < 3000; i++) begin
      if (busy !== 1'b1) break;
      busy_cnt++;
      if (ram_WE_b === 1'b0) begin
        if (ram_A !== we_cnt[AW-1:0] || ram_Din !== 4'h0 || ram_CS_b !== 1'b0) seq_bad++;
        we_cnt++;
      end
      if (inject && busy_cnt == 100) begin
        exp_t e;
        e.chk = 1'b0;
        e.d   = 4'h0;
        cpu_q.push_back(e);
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 10'h001; cpu_wdata = 4'h7;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    int lat, bc, wc, sb, cnt, prev, cur, nack;
    reset = 1'b1; scrub = 1'b1;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    vid_req = 1'b0; vid_addr = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    scrub = 1'b0;

    // Reset values
    check("reset CS_b", int'(ram_CS_b), 1);
    check("reset WE_b", int'(ram_WE_b), 1);
    check("reset ram_A", int'(ram_A), 0);
    check("reset ram_Din", int'(ram_Din), 0);
    check("reset cpu_ack", int'(cpu_ack), 0);
    check("reset vid_valid", int'(vid_valid), 0);
    check("reset cpu_rdata", int'(cpu_rdata), 0);
    check("reset vid_rdata", int'(vid_rdata), 0);
    check("reset busy", int'(busy), 1);

    // Fill, with a CPU write held off until busy falls
    reset = 1'b0;
    fill_watch(1'b1, bc, wc, sb);
    check("fill busy cycles", bc, 1025);
    check("fill write cycles", wc, 1024);
    check("fill address sequence errors", sb, 0);
    check("strobes idle after fill", int'({ram_CS_b, ram_WE_b}), 3);
    cnt = 0;
    while (cpu_ack !== 1'b1 && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    if (cpu_ack !== 1'b1) timeout("held-off cpu write");
    cpu_req = 1'b0;
    vid_op(10'h3FF, 4'h0, lat);
    vid_req = 1'b0;
    vid_op(10'h155, 4'h0, lat);
    vid_req = 1'b0;
    cpu_op(1'b0, 10'h001, 4'h0, 4'h7, lat);

    // CPU write then back-to-back read
    idle(2);
    cpu_op(1'b1, 10'h123, 4'hA, 4'h0, lat);
    check("cpu write latency", lat, 2);
    cpu_op(1'b0, 10'h123, 4'h0, 4'hA, lat);
    check("cpu back-to-back latency", lat, 3);
    idle(1);
    check("cpu rdata held", int'(cpu_rdata), 'hA);
    cpu_op(1'b1, 10'h200, 4'h5, 4'h0, lat);

    // Video latency and request held through the valid cycle
    idle(2);
    vid_op(10'h200, 4'h5, lat);
    check("vid latency", lat, 2);
    @(posedge clk);
    #1 vid_req = 1'b0;
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (vid_valid === 1'b1) cnt++;
    end
    check("vid no second grant", cnt, 0);
    check("vid rdata held", int'(vid_rdata), 5);

    // Contention: both requests held, grants must alternate
    for (int i = 0; i < 3; i++) begin
      exp_t e;
      e.chk = 1'b1;
      e.d = 4'hA; cpu_q.push_back(e);
      e.d = 4'h5; vid_q.push_back(e);
    end
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h123;
    vid_req = 1'b1; vid_addr = 10'h200;
    nack = 0; prev = -1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (cpu_ack === 1'b1 || vid_valid === 1'b1) begin
        cur = (cpu_ack === 1'b1) ? 0 : 1;
        if (nack > 0) check("contention alternates", int'(cur != prev), 1);
        prev = cur;
        nack++;
        if (nack == 6) break;
      end
    end
    cpu_req = 1'b0; vid_req = 1'b0;
    check("contention grant count", nack, 6);
    idle(4);

    // Reset mid-fill
    reset = 1'b1; scrub = 1'b1;
    @(negedge clk);
    reset = 1'b0; scrub = 1'b0;
    cnt = 0;
    while (!(ram_WE_b === 1'b0 && ram_A === 10'h180) && cnt < 2000) begin
      @(negedge clk);
      cnt++;
    end
    if (cnt >= 2000) timeout("reach fill address 0x180");
    reset = 1'b1; scrub = 1'b1;
    @(negedge clk);
    check("abort CS_b", int'(ram_CS_b), 1);
    check("abort WE_b", int'(ram_WE_b), 1);
    check("abort ram_A", int'(ram_A), 0);
    check("abort busy", int'(busy), 1);
    reset = 1'b0; scrub = 1'b0;
    fill_watch(1'b0, bc, wc, sb);
    check("refill busy cycles", bc, 1025);
    check("refill write cycles", wc, 1024);
    check("refill address sequence errors", sb, 0);
    for (int a = 0; a < (1 << AW); a++) begin
      vid_op(a[AW-1:0], 4'h0, lat);
      vid_req = 1'b0;
    end

    idle(3);
    check("cpu scoreboard drained", cpu_q.size(), 0);
    check("vid scoreboard drained", vid_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
